// File: rtl/interp_pkg.sv
// interp_pkg
//   Shared definitions for the two-channel linear interpolator:
//   - mode encodings selecting how mu is chosen per sample
//   - the priming FSM state type (EMPTY -> ONE -> RUN)
//   - the output-width derivation used by the top and the channel MAC
package interp_pkg;

  localparam logic [1:0] MODE_FIX  = 2'd0;
  localparam logic [1:0] MODE_ACC  = 2'd1;
  localparam logic [1:0] MODE_BYP  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_RUN   = 2'd2
  } prime_state_e;

  // Full-precision result width: one extra integer bit for the difference
  // term plus MUW fraction bits.
  function automatic int calc_ow(input int dw, input int muw);
    return dw + muw + 1;
  endfunction

endpackage

// File: rtl/interp_mac.sv
// interp_mac
//   One interpolator channel. Holds the two-sample history (x0 newest,
//   x1 previous), forms diff*mu and the scaled x1 base one cycle after the
//   sample, then adds them into the output register when commit is high.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      shift din into the history (accepted sample)
//   din       signed input sample, DW bits
//   mu        unsigned fraction registered alongside the sample, MUW bits
//   commit    update dout with the interpolated value this cycle
//   dout      signed result, Q(DW+1).MUW, holds when not committed
module interp_mac #(
  parameter int DW  = 8,
  parameter int MUW = 5,
  parameter int OW  = DW + MUW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic signed [DW-1:0] din,
  input  logic [MUW-1:0]       mu,
  input  logic                 commit,
  output logic signed [OW-1:0] dout
);

  logic signed [DW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic signed [DW:0]   diff;
  logic signed [OW-1:0] diff_x, mu_x;
  logic signed [OW-1:0] prod_q, prod_d, base_q, base_d;
  logic signed [OW-1:0] y;
  logic signed [OW-1:0] dout_q, dout_d;

  // mu is zero-extended before the multiply so the product is signed x unsigned;
  // all operands are widened to OW first, and the exact result always fits.
  always_comb begin
    x0_d   = load ? din  : x0_q;
    x1_d   = load ? x0_q : x1_q;
    diff   = (DW+1)'(x0_q) - (DW+1)'(x1_q);
    diff_x = OW'(diff);
    mu_x   = OW'(mu);
    prod_d = diff_x * mu_x;
    base_d = OW'(x1_q) <<< MUW;
    y      = base_q + prod_q;
    dout_d = commit ? y : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q   <= '0;
      x1_q   <= '0;
      prod_q <= '0;
      base_q <= '0;
      dout_q <= '0;
    end else begin
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      prod_q <= prod_d;
      base_q <= base_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/lin_interp_nco.sv
// lin_interp_nco
//   Two-channel (I/Q) linear interpolator y = x1 + mu*(x0 - x1) with a
//   fixed or phase-accumulated mu. An accumulator wrap drops that sample's
//   output and pulses skip instead. Results appear two edges after the
//   sample is accepted.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid         sample qualifier; din_i/din_q signed DW-bit samples
//   mode             0 fixed mu, 1 accumulate, 2 bypass (mu=0), 3 hold
//   mu_fix           mu used in mode 0
//   step, step_wr    accumulator step value and its load strobe
//   acc_clr          clear the accumulator
//   out_valid, skip  single-cycle, mutually exclusive result strobes
//   dout_i, dout_q   signed OW-bit results, Q(DW+1).MUW
module lin_interp_nco
  import interp_pkg::*;
#(
  parameter int DW  = 8,
  parameter int MUW = 5,
  parameter int OW  = calc_ow(DW, MUW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic [1:0]           mode,
  input  logic [MUW-1:0]       mu_fix,
  input  logic [MUW-1:0]       step,
  input  logic                 step_wr,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic signed [OW-1:0] dout_i,
  output logic signed [OW-1:0] dout_q,
  output logic                 skip
);

  prime_state_e   state_q;
  logic [MUW-1:0] acc_q, acc_d;
  logic [MUW-1:0] step_q, step_d;
  logic [MUW-1:0] mu1_q, mu1_d, mu_sel;
  logic [MUW:0]   acc_sum;
  logic           fire, wrap;
  logic           out1_q, out1_d, skip1_q, skip1_d;
  logic           out2_q, skip2_q;
  logic           out_valid_q, skip_q;

  // The sample uses the accumulator value from before this edge; the wrap
  // carry of its update decides whether this sample is dropped.
  always_comb begin
    mu_sel = '0;
    case (mode)
      MODE_FIX:  mu_sel = mu_fix;
      MODE_ACC:  mu_sel = acc_q;
      MODE_BYP:  mu_sel = '0;
      MODE_HOLD: mu_sel = '0;
      default:   mu_sel = '0;
    endcase

    acc_sum = {1'b0, acc_q} + {1'b0, step_q};
    fire    = in_valid && (state_q == ST_RUN);
    wrap    = (mode == MODE_ACC) && acc_sum[MUW];

    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (fire && (mode == MODE_ACC)) begin
      acc_d = acc_sum[MUW-1:0];
    end

    step_d  = step_wr ? step : step_q;
    mu1_d   = in_valid ? mu_sel : mu1_q;
    out1_d  = fire && (mode != MODE_HOLD) && !wrap;
    skip1_d = fire && wrap;
  end

  // Priming: two accepted samples fill the history before output starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else if (in_valid) begin
      case (state_q)
        ST_EMPTY: state_q <= ST_ONE;
        ST_ONE:   state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      step_q      <= '0;
      mu1_q       <= '0;
      out1_q      <= 1'b0;
      skip1_q     <= 1'b0;
      out2_q      <= 1'b0;
      skip2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      step_q      <= step_d;
      mu1_q       <= mu1_d;
      out1_q      <= out1_d;
      skip1_q     <= skip1_d;
      out2_q      <= out1_q;
      skip2_q     <= skip1_q;
      out_valid_q <= out2_q;
      skip_q      <= skip2_q;
    end
  end

  interp_mac #(.DW(DW), .MUW(MUW), .OW(OW)) u_mac_i (
    .clk    (clk),
    .rst    (rst),
    .load   (in_valid),
    .din    (din_i),
    .mu     (mu1_q),
    .commit (out2_q),
    .dout   (dout_i)
  );

  interp_mac #(.DW(DW), .MUW(MUW), .OW(OW)) u_mac_q (
    .clk    (clk),
    .rst    (rst),
    .load   (in_valid),
    .din    (din_q),
    .mu     (mu1_q),
    .commit (out2_q),
    .dout   (dout_q)
  );

  assign out_valid = out_valid_q;
  assign skip      = skip_q;

endmodule

// File: tb/tb_lin_interp_nco.sv
// Testbench for lin_interp_nco (DW=8, MUW=5). A behavioural model keeps
// the last accepted sample, a count of accepted samples since reset, the
// accumulator and the step as plain integers, and computes each result as
// x1*(32-mu) + x0*mu. Expected strobes/values are delayed two edges.
module tb_lin_interp_nco;

  localparam int DW  = 8;
  localparam int MUW = 5;
  localparam int OW  = DW + MUW + 1;
  localparam int ONE = 1 << MUW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] din_i = '0;
  logic signed [DW-1:0] din_q = '0;
  logic [1:0]           mode = '0;
  logic [MUW-1:0]       mu_fix = '0;
  logic [MUW-1:0]       step = '0;
  logic                 step_wr = 1'b0;
  logic                 acc_clr = 1'b0;
  logic                 out_valid;
  logic signed [OW-1:0] dout_i;
  logic signed [OW-1:0] dout_q;
  logic                 skip;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_cnt, m_acc, m_step, m_prev_i, m_prev_q;
  int p_kind [2];
  int p_yi   [2];
  int p_yq   [2];
  logic exp_ov, exp_sk;
  int   exp_di, exp_dq;

  lin_interp_nco #(.DW(DW), .MUW(MUW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din_i     (din_i),
    .din_q     (din_q),
    .mode      (mode),
    .mu_fix    (mu_fix),
    .step      (step),
    .step_wr   (step_wr),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .dout_i    (dout_i),
    .dout_q    (dout_q),
    .skip      (skip)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_cnt = 0; m_acc = 0; m_step = 0; m_prev_i = 0; m_prev_q = 0;
    for (int k = 0; k < 2; k++) begin
      p_kind[k] = 0; p_yi[k] = 0; p_yq[k] = 0;
    end
    exp_ov = 1'b0; exp_sk = 1'b0; exp_di = 0; exp_dq = 0;
  endtask

  // Advance the model by one clock edge using the inputs driven this cycle.
  task automatic modelEdge();
    int kind, yi, yq, mu, nxt, acc_new;
    kind = 0; yi = 0; yq = 0; mu = 0; acc_new = m_acc;
    if (in_valid) begin
      if (m_cnt >= 2) begin
        case (mode)
          2'd0:    mu = int'(mu_fix);
          2'd1:    mu = m_acc;
          default: mu = 0;
        endcase
        if (mode == 2'd1) begin
          nxt = m_acc + m_step;
          if (nxt >= ONE) begin
            kind = 2; acc_new = nxt - ONE;
          end else begin
            kind = 1; acc_new = nxt;
          end
        end else if (mode != 2'd3) begin
          kind = 1;
        end
        yi = m_prev_i * (ONE - mu) + int'(din_i) * mu;
        yq = m_prev_q * (ONE - mu) + int'(din_q) * mu;
      end
      m_prev_i = int'(din_i);
      m_prev_q = int'(din_q);
      if (m_cnt < 2) m_cnt++;
    end
    m_acc = acc_clr ? 0 : acc_new;
    if (step_wr) m_step = int'(step);

    exp_ov = (p_kind[1] == 1);
    exp_sk = (p_kind[1] == 2);
    if (p_kind[1] == 1) begin
      exp_di = p_yi[1];
      exp_dq = p_yq[1];
    end
    p_kind[1] = p_kind[0]; p_yi[1] = p_yi[0]; p_yq[1] = p_yq[0];
    p_kind[0] = kind;      p_yi[0] = yi;      p_yq[0] = yq;
  endtask

  task automatic checkOutput();
    n_cmp += 4;
    assert (out_valid === exp_ov) else begin
      n_err++;
      $error("[TB] FAIL out_valid t=%0t got=%0b exp=%0b", $time, out_valid, exp_ov);
    end
    assert (skip === exp_sk) else begin
      n_err++;
      $error("[TB] FAIL skip t=%0t got=%0b exp=%0b", $time, skip, exp_sk);
    end
    assert (int'(dout_i) === exp_di) else begin
      n_err++;
      $error("[TB] FAIL dout_i t=%0t got=%0d exp=%0d", $time, dout_i, exp_di);
    end
    assert (int'(dout_q) === exp_dq) else begin
      n_err++;
      $error("[TB] FAIL dout_q t=%0t got=%0d exp=%0d", $time, dout_q, exp_dq);
    end
  endtask

  task automatic checkConst(input string tag, input int got, input int expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, check #1 later.
  task automatic applyStimulus(input logic v, input int di, input int dq,
                               input int md, input int mf, input int st,
                               input logic sw, input logic clr);
    in_valid = v;
    din_i    = DW'(di);
    din_q    = DW'(dq);
    mode     = 2'(md);
    mu_fix   = MUW'(mf);
    step     = MUW'(st);
    step_wr  = sw;
    acc_clr  = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges: outputs must clear immediately.
  task automatic doReset();
    in_valid = 1'b0; step_wr = 1'b0; acc_clr = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    #2;
    doReset();

    // Fixed mu = 0.5
    applyStimulus(1'b1, 5,   -5,  0, 16, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10,  -10, 0, 16, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 30,  40,  0, 16, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("fix_mu16_i", int'(dout_i), 640);
    checkConst("fix_mu16_q", int'(dout_q), 480);

    // Extremes
    applyStimulus(1'b1, -128, 0, 0, 31, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 127,  0, 0, 31, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("mu31_extreme", int'(dout_i), 3809);
    applyStimulus(1'b1, -128, 0, 0, 31, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5,    0, 0, 0,  0, 1'b0, 1'b0);
    idle(2);
    checkConst("mu0_extreme", int'(dout_i), -4096);

    // Accumulate with wrap, step 12 from a cleared accumulator
    applyStimulus(1'b0, 0, 0, 1, 0, 12, 1'b1, 1'b1);
    applyStimulus(1'b1, 20, 1, 1, 0, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("acc_mu0", int'(dout_i), 160);
    applyStimulus(1'b1, 40, 2, 1, 0, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("acc_mu12", int'(dout_i), 880);
    applyStimulus(1'b1, 60, 3, 1, 0, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("acc_wrap_skip", int'(skip), 1);
    checkConst("acc_wrap_novalid", int'(out_valid), 0);
    applyStimulus(1'b1, 80, 4, 1, 0, 0, 1'b0, 1'b0);
    idle(2);
    checkConst("acc_mu4", int'(dout_i), 2000);

    // step_wr with a sample, then acc_clr with a sample
    applyStimulus(1'b1, 100, -50, 1, 0, 20, 1'b1, 1'b0);
    applyStimulus(1'b1, -90, 70,  1, 0, 0,  1'b0, 1'b0);
    applyStimulus(1'b1, 33,  -33, 1, 0, 0,  1'b0, 1'b0);
    applyStimulus(1'b1, 50,  11,  1, 0, 0,  1'b0, 1'b1);
    applyStimulus(1'b1, -60, 12,  1, 0, 0,  1'b0, 1'b0);
    idle(2);

    // Bypass, hold, and gaps of 0..3 idle cycles
    applyStimulus(1'b1, -7,  3,  2, 9, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 44,  -2, 3, 9, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 90,  8,  1, 0, 0, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      idle(g);
      applyStimulus(1'b1, 10 * g - 15, 7 - g, 0, 8 * g + 3, 0, 1'b0, 1'b0);
    end
    idle(2);

    // Randomised traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus(($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lin_interp_nco.md
# lin_interp_nco

Parametrised two-channel (I/Q) linear interpolator for the carrier/timing-offset correction path, successor to the fixed three-ratio interpolator. It computes y = x[n-1] + mu·(x[n] − x[n-1]) at full precision with a programmable fractional mu, and can either hold mu fixed or advance it with an internal phase accumulator. When the accumulator wraps, one output is dropped and a skip strobe is raised. The block sits between the ADC sample stream and the downstream offset-compensation stage.

## Interface
- DW, 8, input sample width (signed)
- MUW, 5, mu fraction width; mu in [0, 1 − 2^-MUW]
- OW, DW+MUW+1, output width (derived; do not override)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample qualifier
- din_i, din_q  in  DW  signed samples
- mode  in  2  0 fixed mu, 1 accumulate, 2 bypass, 3 hold
- mu_fix  in  MUW  unsigned mu used in mode 0
- step  in  MUW  unsigned accumulator step
- step_wr  in  1  load step into the internal register
- acc_clr  in  1  clear the accumulator to 0
- out_valid  out  1  output qualifier
- dout_i, dout_q  out  OW  signed, Q(DW+1).MUW
- skip  out  1  one-cycle pulse marking a dropped output

## Operation
- A sample is accepted on any clk edge where in_valid=1. Pipeline registers: x0 ← din, and x1 ← previous x0.
- Priming FSM, states EMPTY → ONE → RUN:
  - Each accepted sample advances one state.
  - RUN persists.
  - No output is produced in EMPTY or ONE.
- Arithmetic per channel:
  - diff = x0 − x1, DW+1 bits.
  - prod = diff·mu, DW+MUW+1 bits, signed × unsigned.
  - y = (x1 sign-extended <<< MUW) + prod.
  - Exact result: no rounding, no saturation; cannot overflow OW.
- mu selection per sample:
  - mode 0: mu_fix.
  - mode 1: acc.
  - mode 2: mu = 0, so y = x1 <<< MUW.
  - mode 3: sample is accepted, but no output is produced and acc is frozen.
- Accumulator (mode 1 only):
  - On each accepted sample in RUN, {carry, acc} ← acc + step_reg.
  - If carry=1, that sample's output is suppressed and skip pulses instead of out_valid.
- acc is held in modes 0, 2 and 3.
- acc_clr has priority over the update. The sample accepted in the same cycle still uses the old acc.
- step_wr in the same cycle as an accepted sample: that sample's update uses the old step_reg; the new value applies from the next sample.
- mode and mu_fix are sampled together with the sample. A mode change affects only later samples.

## Timing
- Latency: a sample accepted at edge k produces out_valid/dout (or skip) at edge k+2, meaning visible after edge k+2.
- out_valid and skip are single-cycle and mutually exclusive.
- Throughput: one sample per clk. in_valid may toggle arbitrarily; there is no backpressure.
- dout holds its last value when out_valid=0.
- Reset values: x0, x1, acc, step_reg = 0; FSM = EMPTY; out_valid = 0; skip = 0; dout_i = dout_q = 0.
- Reset mid-stream:
  - All in-flight results are discarded.
  - The next two accepted samples re-prime the FSM before any output appears.

## Structure
- Package interp_pkg holds:
  - mode encoding constants (MODE_FIX, MODE_ACC, MODE_BYP, MODE_HOLD);
  - the prime-FSM state typedef;
  - the OW derivation function.
- Sub-module interp_mac: one channel, holding x0/x1, the diff/prod/y datapath and the output register. It is instantiated twice (I, Q).
- The top level holds the FSM, mu mux, accumulator and the valid/skip pipeline.

## Test plan
- Fixed mu, DW=8, MUW=5:
  - mode 0, mu_fix=16; I samples 10 then 30 → second output dout_i=640 (20.0).
  - First sample after reset → no out_valid.
- Extremes: mode 0, mu_fix=31, x1=−128, x0=127 → dout=3809; mu_fix=0 → dout=−4096.
- Accumulate with wrap: mode 1, step=12 after acc_clr.
  - Successive outputs use mu 0, 12.
  - Third sample (mu=24) → skip=1, out_valid=0.
  - acc becomes 4; next output uses mu=4.
- Simultaneous events:
  - step_wr (step=20) with an accepted sample → that sample's update still uses 12.
  - acc_clr with a sample → output uses the old acc; the following sample uses mu=0.
- Modes 2/3 and gaps:
  - mode 2 → dout = x1·32.
  - mode 3 → no out_valid, acc unchanged.
  - in_valid gaps of 0–3 cycles → latency stays exactly 2 cycles from acceptance.
- Reset mid-stream: assert rst during RUN with results in flight → all outputs 0 immediately; first out_valid only after two new samples.
